// File: rtl/vga_pkg.sv
// Shared frame-buffer geometry and writer state encoding for the VGA write and display paths.
package vga_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam int DEF_PXL_BITS       = 3;
  localparam int DEF_MEM_DATA_WIDTH = 24;
  localparam int DEF_MEM_ADDR_WIDTH = 16;
  localparam int DEF_FRAME_WORDS    = 38400;
  localparam int DEF_PPW            = DEF_MEM_DATA_WIDTH / DEF_PXL_BITS;

endpackage

// File: rtl/vga_frame_writer.sv
// Packs a 3-bit pixel stream into 24-bit frame-buffer words and writes them at a wrapping frame address.
// Optional sticky framing error output sof_err_o when VGA_FRAME_WRITER_SOF_ERR_EN is defined.
//
// state | meaning
// IDLE  | waiting for the first SOF pixel; non-SOF pixels are dropped
// PACK  | collecting pixels into the packing register
// WRITE | full word presented on the memory port, waiting for mem_wready_i
module vga_frame_writer
  import vga_pkg::*;
#(
  parameter int MEM_DATA_WIDTH = DEF_MEM_DATA_WIDTH,
  parameter int MEM_ADDR_WIDTH = DEF_MEM_ADDR_WIDTH,
  parameter int PXL_BITS       = DEF_PXL_BITS,
  parameter int FRAME_WORDS    = DEF_FRAME_WORDS
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      pxl_valid_i,
  output logic                      pxl_ready_o,
  input  logic [PXL_BITS-1:0]       pxl_data_i,
  input  logic                      pxl_sof_i,
  output logic                      mem_wen_o,
  input  logic                      mem_wready_i,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [MEM_DATA_WIDTH-1:0] mem_data_o,
  output logic                      frame_done_o
`ifdef VGA_FRAME_WRITER_SOF_ERR_EN
  ,
  output logic                      sof_err_o
`endif
);

  localparam int PPW   = MEM_DATA_WIDTH / PXL_BITS;
  localparam int CNT_W = (PPW > 1) ? $clog2(PPW) : 1;
  localparam logic [CNT_W-1:0]          SLOT_LAST = CNT_W'(PPW - 1);
  localparam logic [MEM_ADDR_WIDTH-1:0] ADDR_LAST = MEM_ADDR_WIDTH'(FRAME_WORDS - 1);

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          slot_q, slot_sel;
  logic [MEM_DATA_WIDTH-1:0] pack_q, pack_d, data_q;
  logic [MEM_ADDR_WIDTH-1:0] addr_q;
  logic                      done_q;
  logic                      px_acc, wr_acc, word_full, px_store;

  always_comb begin
    state_d     = state_q;
    pxl_ready_o = (state_q != WRITE);
    mem_wen_o   = (state_q == WRITE);
    px_acc      = pxl_valid_i & pxl_ready_o;
    wr_acc      = mem_wen_o & mem_wready_i;
    px_store    = px_acc & (pxl_sof_i | (state_q == PACK));
    // SOF restarts the word: any partial contents are discarded
    slot_sel    = pxl_sof_i ? '0 : slot_q;
    pack_d      = pxl_sof_i ? '0 : pack_q;
    pack_d[slot_sel*PXL_BITS +: PXL_BITS] = pxl_data_i;
    word_full   = (slot_sel == SLOT_LAST);
    case (state_q)
      IDLE:    if (px_store) state_d = word_full ? WRITE : PACK;
      PACK:    if (px_store && word_full) state_d = WRITE;
      WRITE:   if (wr_acc) state_d = PACK;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      slot_q  <= '0;
      pack_q  <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      if (px_store) begin
        if (pxl_sof_i) addr_q <= '0;
        if (word_full) begin
          data_q <= pack_d;
          slot_q <= '0;
        end else begin
          pack_q <= pack_d;
          slot_q <= slot_sel + 1'b1;
        end
      end
      if (wr_acc) begin
        if (addr_q == ADDR_LAST) begin
          addr_q <= '0;
          done_q <= 1'b1;
        end else begin
          addr_q <= addr_q + 1'b1;
        end
      end
    end
  end

  assign mem_addr_o   = addr_q;
  assign mem_data_o   = data_q;
  assign frame_done_o = done_q;

`ifdef VGA_FRAME_WRITER_SOF_ERR_EN
  logic wrapped_q, err_q;

  // wrapped_q marks that the address wrapped with no SOF seen since
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wrapped_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (wr_acc && (addr_q == ADDR_LAST)) wrapped_q <= 1'b1;
      if (px_acc && pxl_sof_i) wrapped_q <= 1'b0;
      if (px_acc && pxl_sof_i && (state_q == PACK) && (slot_q != '0)) err_q <= 1'b1;
      if (px_acc && !pxl_sof_i && (state_q == PACK) && (slot_q == '0) &&
          (addr_q == '0) && wrapped_q) err_q <= 1'b1;
    end
  end

  assign sof_err_o = err_q;
`endif

endmodule

// File: tb/tb_vga_frame_writer.sv
// Randomized and directed bench for vga_frame_writer against a queue-based frame model (FRAME_WORDS=4).
module tb_vga_frame_writer;

  localparam int FW  = 4;
  localparam int PPW = 8;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        pxl_valid_i = 1'b0;
  logic        pxl_ready_o;
  logic [2:0]  pxl_data_i = '0;
  logic        pxl_sof_i = 1'b0;
  logic        mem_wen_o;
  logic        mem_wready_i = 1'b0;
  logic [15:0] mem_addr_o;
  logic [23:0] mem_data_o;
  logic        frame_done_o;
`ifdef VGA_FRAME_WRITER_SOF_ERR_EN
  logic        sof_err_o;
`endif

  vga_frame_writer #(
    .MEM_DATA_WIDTH(24),
    .MEM_ADDR_WIDTH(16),
    .PXL_BITS(3),
    .FRAME_WORDS(FW)
  ) dut (
    .clk_i(clk_i),
    .rstn_i(rstn_i),
    .pxl_valid_i(pxl_valid_i),
    .pxl_ready_o(pxl_ready_o),
    .pxl_data_i(pxl_data_i),
    .pxl_sof_i(pxl_sof_i),
    .mem_wen_o(mem_wen_o),
    .mem_wready_i(mem_wready_i),
    .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o),
    .frame_done_o(frame_done_o)
`ifdef VGA_FRAME_WRITER_SOF_ERR_EN
    ,
    .sof_err_o(sof_err_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  bit   rand_wr  = 1'b0;
  logic wr_force = 1'b1;

  always @(posedge clk_i) begin
    #1;
    mem_wready_i = rand_wr ? ($urandom_range(0, 9) < 7) : wr_force;
  end

  // frame model: pixels of the current word, pending write, frame position
  int    pix[$];
  bit    m_busy, m_in_frame, m_wrapped, m_done, m_err;
  int    m_addr;
  longint m_word;
  int    m_writes = 0;
  int    dut_writes = 0, dut_dones = 0, stall = 0;
  int    dut_last_addr = 0;
  logic [23:0] dut_last_data = '0;

  task automatic model_pixel(input int d, input bit s);
    if (s) begin
      if (m_in_frame && pix.size() != 0) m_err = 1;
      pix.delete();
      m_addr     = 0;
      m_in_frame = 1;
      m_wrapped  = 0;
    end else if (!m_in_frame) begin
      return;
    end else if (pix.size() == 0 && m_addr == 0 && m_wrapped) begin
      m_err = 1;
    end
    pix.push_back(d);
    if (pix.size() == PPW) begin
      m_word = 0;
      for (int k = 0; k < PPW; k++) m_word += longint'(pix[k]) * (longint'(1) << (3 * k));
      m_busy = 1;
      pix.delete();
    end
  endtask

  always @(negedge clk_i) begin
    if (!rstn_i) begin
      pix.delete();
      m_busy = 0; m_in_frame = 0; m_wrapped = 0; m_done = 0; m_err = 0; m_addr = 0;
    end else begin
      check("ready", pxl_ready_o, !m_busy);
      check("wen", mem_wen_o, m_busy);
      if (m_busy) begin
        check("addr", mem_addr_o, m_addr);
        check("data", mem_data_o, 32'(m_word));
      end
      check("frame_done", frame_done_o, m_done);
`ifdef VGA_FRAME_WRITER_SOF_ERR_EN
      check("sof_err", sof_err_o, m_err);
`endif
      if (mem_wen_o && mem_wready_i) begin
        dut_writes++;
        dut_last_addr = mem_addr_o;
        dut_last_data = mem_data_o;
      end
      if (mem_wen_o && !mem_wready_i) stall++;
      if (frame_done_o) dut_dones++;
      m_done = 0;
      if (m_busy) begin
        if (mem_wready_i) begin
          m_busy = 0;
          m_writes++;
          if (m_addr == FW - 1) begin
            m_addr = 0; m_done = 1; m_wrapped = 1;
          end else begin
            m_addr++;
          end
        end
      end else if (pxl_valid_i) begin
        model_pixel(int'(pxl_data_i), pxl_sof_i);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic send_px(input logic [2:0] d, input logic s);
    int n = 0;
    pxl_valid_i = 1'b1; pxl_data_i = d; pxl_sof_i = s;
    while (1) begin
      @(negedge clk_i);
      if (pxl_ready_o) break;
      n++;
      if (n > 200) begin
        check("px_accept_timeout", 32'(n), 0);
        break;
      end
    end
    @(posedge clk_i); #1;
    pxl_valid_i = 1'b0; pxl_sof_i = 1'b0;
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    idle(2);
    rstn_i = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  int base, st, dn;

  initial begin
    idle(2);
    rstn_i = 1'b1;
    #2;
    check("rst_ready", pxl_ready_o, 1);
    check("rst_wen", mem_wen_o, 0);
    check("rst_addr", mem_addr_o, 0);
    check("rst_data", mem_data_o, 0);
    check("rst_done", frame_done_o, 0);
    idle(1);

    // basic word 0..7
    base = dut_writes; wr_force = 1'b1;
    send_px(3'd0, 1'b1);
    for (int i = 1; i < 8; i++) send_px(3'(i), 1'b0);
    idle(3);
    check("t1_writes", 32'(dut_writes - base), 1);
    check("t1_addr", 32'(dut_last_addr), 0);
    check("t1_data", dut_last_data, 32'hFAC688);

    // memory back-pressure
    base = dut_writes; st = stall; wr_force = 1'b0;
    send_px(3'd0, 1'b1);
    for (int i = 1; i < 8; i++) send_px(3'(i), 1'b0);
    repeat (5) @(posedge clk_i);
    #2; wr_force = 1'b1;
    idle(4);
    check("t2_writes", 32'(dut_writes - base), 1);
    check("t2_stall_ge5", 32'(stall - st >= 5), 1);
    check("t2_data", dut_last_data, 32'hFAC688);

    // no-SOF pixels after reset are dropped
    do_reset();
    base = dut_writes;
    for (int i = 0; i < 8; i++) send_px(3'($urandom_range(0, 7)), 1'b0);
    idle(3);
    check("t3_dropped", 32'(dut_writes - base), 0);
    send_px(3'($urandom_range(0, 7)), 1'b1);
    for (int i = 1; i < 8; i++) send_px(3'($urandom_range(0, 7)), 1'b0);
    idle(3);
    check("t3_writes", 32'(dut_writes - base), 1);
    check("t3_addr", 32'(dut_last_addr), 0);

    // whole frame of value 5, wrap and next frame word
    base = dut_writes; dn = dut_dones;
    send_px(3'd5, 1'b1);
    for (int i = 1; i < 32; i++) send_px(3'd5, 1'b0);
    idle(3);
    check("t4_writes", 32'(dut_writes - base), 4);
    check("t4_last_addr", 32'(dut_last_addr), 3);
    check("t4_data", dut_last_data, 32'hB6DB6D);
    check("t4_done", 32'(dut_dones - dn), 1);
    for (int i = 0; i < 8; i++) send_px(3'd5, 1'b0);
    idle(3);
    check("t4_wrap_addr", 32'(dut_last_addr), 0);
    check("t4_done_once", 32'(dut_dones - dn), 1);

    // SOF discards a partial word
    do_reset();
    base = dut_writes;
    send_px(3'd1, 1'b1);
    send_px(3'd2, 1'b0);
    send_px(3'd3, 1'b0);
    for (int i = 0; i < 8; i++) send_px(3'(7 - i), (i == 0));
    idle(3);
    check("t5_writes", 32'(dut_writes - base), 1);
    check("t5_addr", 32'(dut_last_addr), 0);
    check("t5_data", dut_last_data, 32'h053977);
`ifdef VGA_FRAME_WRITER_SOF_ERR_EN
    check("t5_sof_err", sof_err_o, 1);
`endif

    // reset during a pending write
    do_reset();
    base = dut_writes; wr_force = 1'b0;
    send_px(3'd4, 1'b1);
    for (int i = 1; i < 8; i++) send_px(3'd6, 1'b0);
    idle(2);
    check("t6_wen_pre", mem_wen_o, 1);
    #2; rstn_i = 1'b0;
    #1;
    check("t6_wen_rst", mem_wen_o, 0);
    check("t6_addr_rst", mem_addr_o, 0);
    check("t6_ready_rst", pxl_ready_o, 1);
    idle(2);
    rstn_i = 1'b1; wr_force = 1'b1;
    for (int i = 0; i < 8; i++) send_px(3'($urandom_range(0, 7)), 1'b0);
    idle(3);
    check("t6_dropped", 32'(dut_writes - base), 0);

    // randomized stream with random back-pressure
    base = dut_writes; st = m_writes; rand_wr = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send_px(3'($urandom_range(0, 7)), (i == 0) || ($urandom_range(0, 39) == 0));
    end
    rand_wr = 1'b0; wr_force = 1'b1;
    idle(6);
    check("rand_writes", 32'(dut_writes - base), 32'(m_writes - st));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
